bc_buffer: RTL and testbench
============================

# bc_buffer

Bidirectional buffer between the control block ("ctrl") and the avoidance block ("avoid"). It contains two independent synchronous FIFOs of 16-bit words:
- **Old path:** ctrl → avoid, written through `ctrl_in_*` and read through `avoid_out_*`.
- **New path:** avoid → ctrl, written through `avoid_in_*` and read through `ctrl_out_*`.

Each side uses a ready/valid handshake, so either block can produce and consume at its own rate.

## Interface
Parameters:
- DATA_WIDTH, 16, word width of both FIFOs.
- DEPTH, 16, entries per FIFO; must be a power of two.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- ctrl_in_valid  in  1  ctrl offers a word on the old path.
- ctrl_in_data  in  16  word offered by ctrl.
- ctrl_in_rdy  out  1  old FIFO can accept a word (not full).
- avoid_out_rdy  in  1  avoid requests a pop from the old FIFO.
- avoid_out_valid  out  1  old FIFO holds a readable word.
- avoid_out_data  out  16  word most recently popped from the old FIFO.
- avoid_in_valid  in  1  avoid offers a word on the new path.
- avoid_in_data  in  16  word offered by avoid.
- avoid_in_rdy  out  1  new FIFO can accept a word (not full).
- ctrl_out_rdy  in  1  ctrl requests a pop from the new FIFO.
- ctrl_out_valid  out  1  new FIFO holds a readable word.
- ctrl_out_data  out  16  word most recently popped from the new FIFO.

## Operation
The two FIFOs are identical and fully independent; there is no cross-path interaction. Each FIFO is described below by role:

| Role | Old path | New path |
|---|---|---|
| in_valid | ctrl_in_valid | avoid_in_valid |
| in_data | ctrl_in_data | avoid_in_data |
| in_rdy | ctrl_in_rdy | avoid_in_rdy |
| out_rdy | avoid_out_rdy | ctrl_out_rdy |
| out_valid | avoid_out_valid | ctrl_out_valid |
| out_data | avoid_out_data | ctrl_out_data |

State per FIFO:
- DEPTH×16 storage array.
- Write and read pointers, each log2(DEPTH)+1 bits, wrapping modulo 2·DEPTH.
- wr_ptr_q: a one-cycle-delayed copy of the write pointer.
- out_data register.

Write:
- Occurs when in_valid && in_rdy at a rising edge.
- Stores in_data at mem[wr_ptr mod DEPTH], then increments wr_ptr.

Full and ready:
- full = (wr_ptr − rd_ptr) == DEPTH.
- in_rdy = !full && !rst.
- A write while full is ignored; no overwrite occurs.

Valid:
- out_valid = (rd_ptr != wr_ptr_q).
- A written word becomes readable one cycle after its write edge.

Pop:
- Occurs when out_rdy && out_valid at a rising edge.
- out_data loads mem[rd_ptr mod DEPTH], then rd_ptr increments.
- out_data holds its value at all other times, including when out_rdy is high with out_valid low.
- A pop while empty is ignored; the pointers never underflow.

Simultaneous write and pop in the same cycle are both performed.

Reset (also applies mid-operation):
- Both FIFOs flush: pointers and wr_ptr_q cleared.
- out_valid = 0.
- out_data = 0.
- in_rdy = 0 during reset.
- Memory contents need not be cleared.

## Timing
- Reset values: ctrl_in_rdy = avoid_in_rdy = 0; avoid_out_valid = ctrl_out_valid = 0; avoid_out_data = ctrl_out_data = 0x0000.
- in_rdy goes high on the first cycle after rst deasserts.
- Write-to-valid latency: a word written at edge N gives out_valid = 1 after edge N+1.
- Read data latency: a pop accepted at edge M presents its word on out_data immediately after edge M, held until the next accepted pop. This is standard-mode FIFO read, not first-word-fall-through.
- out_valid drops in the same cycle the last word is popped, with no lag. With out_rdy held high, exactly as many pops occur as words were written.
- Full is visible on in_rdy the cycle after the DEPTH-th write.
- Pointer wrap-around must preserve ordering across an arbitrary number of passes.

## Test plan
- **Reset:** hold rst for 1 cycle → all valid/rdy outputs 0 and data 0x0000 during reset; in_rdy = 1 on the next cycle; out_valid stays 0.
- **Old path ordering:** ctrl writes 10..19 on 10 consecutive cycles with avoid_out_rdy = 0 → avoid_out_valid is 0 one edge after the first write and 1 from the second edge. Then raise avoid_out_rdy → avoid_out_data reads 0x0A..0x13 on successive cycles, and avoid_out_valid = 0 after the 10th pop.
- **New path ordering:** avoid writes 20..29, wait 2 cycles, hold ctrl_out_rdy = 1 → ctrl_out_data reads 0x14..0x1D in order. No 11th pop occurs; ctrl_out_data holds 0x1D.
- **Full:** write 17 words without popping → avoid_in_rdy = 0 after the 16th write. The 17th word is dropped, and a read-back yields exactly the first 16 words.
- **Concurrent paths and wrap-around:** stream 40 words through both paths simultaneously with random valid/rdy → each path's output matches its own input order, with no cross-talk and no loss.
- **Mid-operation reset:** assert rst with 5 words queued → out_valid = 0 on the next cycle, and subsequent writes read back starting from the first new word.

Source files
------------

// File: rtl/bc_buffer.sv
// ============================================================================
// Module   : bc_buffer
// Brief    : Two independent ready/valid FIFOs between the ctrl and avoid blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bc_buffer_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_in_rdy,
    input  logic                  i_out_rdy,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data
);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam logic [c_PTR_W-1:0] c_FULL_CNT = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr_q;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic [c_PTR_W-1:0]    w_count;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_rd_en;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == c_FULL_CNT);
    assign o_in_rdy    = !w_full && !rst;
    // Valid tracks the delayed write pointer so a word is readable one cycle after its write.
    assign o_out_valid = (r_rd_ptr != r_wr_ptr_q);
    assign w_wr_en     = i_in_valid && o_in_rdy;
    assign w_rd_en     = i_out_rdy && o_out_valid;
    assign o_out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_wr_ptr_q <= '0;
            r_rd_ptr   <= '0;
            r_out_data <= '0;
        end else begin
            r_wr_ptr_q <= r_wr_ptr;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_out_data <= r_mem[r_rd_ptr[c_ADDR_W-1:0]];
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end
endmodule

module bc_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_in_valid,
    input  logic [DATA_WIDTH-1:0] ctrl_in_data,
    output logic                  ctrl_in_rdy,
    input  logic                  avoid_out_rdy,
    output logic                  avoid_out_valid,
    output logic [DATA_WIDTH-1:0] avoid_out_data,
    input  logic                  avoid_in_valid,
    input  logic [DATA_WIDTH-1:0] avoid_in_data,
    output logic                  avoid_in_rdy,
    input  logic                  ctrl_out_rdy,
    output logic                  ctrl_out_valid,
    output logic [DATA_WIDTH-1:0] ctrl_out_data
);
    // Old path: ctrl -> avoid
    bc_buffer_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_old_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (ctrl_in_valid),
        .i_in_data   (ctrl_in_data),
        .o_in_rdy    (ctrl_in_rdy),
        .i_out_rdy   (avoid_out_rdy),
        .o_out_valid (avoid_out_valid),
        .o_out_data  (avoid_out_data)
    );

    // New path: avoid -> ctrl
    bc_buffer_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_new_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (avoid_in_valid),
        .i_in_data   (avoid_in_data),
        .o_in_rdy    (avoid_in_rdy),
        .i_out_rdy   (ctrl_out_rdy),
        .o_out_valid (ctrl_out_valid),
        .o_out_data  (ctrl_out_data)
    );
endmodule

`default_nettype wire

// File: tb/tb_bc_buffer.sv
// ============================================================================
// Module   : tb_bc_buffer
// Brief    : Directed self-checking bench for bc_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bc_buffer;
    logic        clk;
    logic        rst;
    logic        ctrl_in_valid;
    logic [15:0] ctrl_in_data;
    logic        ctrl_in_rdy;
    logic        avoid_out_rdy;
    logic        avoid_out_valid;
    logic [15:0] avoid_out_data;
    logic        avoid_in_valid;
    logic [15:0] avoid_in_data;
    logic        avoid_in_rdy;
    logic        ctrl_out_rdy;
    logic        ctrl_out_valid;
    logic [15:0] ctrl_out_data;

    int n_checks;
    int n_fail;

    bc_buffer #(
        .DATA_WIDTH (16),
        .DEPTH      (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_in_valid   (ctrl_in_valid),
        .ctrl_in_data    (ctrl_in_data),
        .ctrl_in_rdy     (ctrl_in_rdy),
        .avoid_out_rdy   (avoid_out_rdy),
        .avoid_out_valid (avoid_out_valid),
        .avoid_out_data  (avoid_out_data),
        .avoid_in_valid  (avoid_in_valid),
        .avoid_in_data   (avoid_in_data),
        .avoid_in_rdy    (avoid_in_rdy),
        .ctrl_out_rdy    (ctrl_out_rdy),
        .ctrl_out_valid  (ctrl_out_valid),
        .ctrl_out_data   (ctrl_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] q_old[$];
    logic [15:0] q_new[$];
    int          sent_old, sent_new, rcv_old, rcv_new;
    logic        acc_wo, acc_wn, acc_ro, acc_rn;
    logic [15:0] exp_w;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        ctrl_in_valid = 1'b0; ctrl_in_data = '0; avoid_out_rdy = 1'b0;
        avoid_in_valid = 1'b0; avoid_in_data = '0; ctrl_out_rdy = 1'b0;

        // Reset state
        tick();
        check("rst_ctrl_in_rdy",     ctrl_in_rdy,     0);
        check("rst_avoid_in_rdy",    avoid_in_rdy,    0);
        check("rst_avoid_out_valid", avoid_out_valid, 0);
        check("rst_ctrl_out_valid",  ctrl_out_valid,  0);
        check("rst_avoid_out_data",  avoid_out_data,  0);
        check("rst_ctrl_out_data",   ctrl_out_data,   0);
        rst = 1'b0;
        tick();
        check("post_rst_ctrl_in_rdy",  ctrl_in_rdy,     1);
        check("post_rst_avoid_in_rdy", avoid_in_rdy,    1);
        check("post_rst_old_valid",    avoid_out_valid, 0);
        check("post_rst_new_valid",    ctrl_out_valid,  0);

        // Old path ordering
        for (int i = 0; i < 10; i++) begin
            ctrl_in_valid = 1'b1;
            ctrl_in_data  = 16'(10 + i);
            tick();
            if (i == 0) check("old_valid_lat0", avoid_out_valid, 0);
            if (i == 1) check("old_valid_lat1", avoid_out_valid, 1);
        end
        ctrl_in_valid = 1'b0;
        avoid_out_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("old_data", avoid_out_data, 32'(10 + k));
        end
        check("old_valid_empty", avoid_out_valid, 0);
        avoid_out_rdy = 1'b0;

        // New path ordering, no extra pop
        for (int i = 0; i < 10; i++) begin
            avoid_in_valid = 1'b1;
            avoid_in_data  = 16'(20 + i);
            tick();
        end
        avoid_in_valid = 1'b0;
        tick();
        tick();
        ctrl_out_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("new_data", ctrl_out_data, 32'(20 + k));
        end
        tick();
        tick();
        check("new_hold_data", ctrl_out_data, 32'h1D);
        check("new_valid_empty", ctrl_out_valid, 0);
        ctrl_out_rdy = 1'b0;

        // Full: 17 writes, 17th dropped
        for (int i = 0; i < 17; i++) begin
            avoid_in_valid = 1'b1;
            avoid_in_data  = 16'(16'h100 + i);
            tick();
            if (i == 14) check("full_rdy_before", avoid_in_rdy, 1);
            if (i == 15) check("full_rdy_after", avoid_in_rdy, 0);
        end
        avoid_in_valid = 1'b0;
        ctrl_out_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            check("full_data", ctrl_out_data, 32'(16'h100 + k));
        end
        tick();
        tick();
        check("full_no_17th_valid", ctrl_out_valid, 0);
        check("full_no_17th_data",  ctrl_out_data,  32'h10F);
        ctrl_out_rdy = 1'b0;

        // Concurrent random streaming
        sent_old = 0; sent_new = 0; rcv_old = 0; rcv_new = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (rcv_old == 40 && rcv_new == 40) break;
            ctrl_in_valid  = (sent_old < 40) && ($urandom_range(0, 1) == 1);
            ctrl_in_data   = 16'(16'hA000 + sent_old);
            avoid_in_valid = (sent_new < 40) && ($urandom_range(0, 1) == 1);
            avoid_in_data  = 16'(16'hB000 + sent_new);
            avoid_out_rdy  = ($urandom_range(0, 1) == 1);
            ctrl_out_rdy   = ($urandom_range(0, 1) == 1);
            acc_wo = ctrl_in_valid && ctrl_in_rdy;
            acc_wn = avoid_in_valid && avoid_in_rdy;
            acc_ro = avoid_out_rdy && avoid_out_valid;
            acc_rn = ctrl_out_rdy && ctrl_out_valid;
            tick();
            if (acc_ro) begin
                exp_w = (q_old.size() > 0) ? q_old.pop_front() : 16'hDEAD;
                check("conc_old_data", avoid_out_data, exp_w);
                rcv_old++;
            end
            if (acc_rn) begin
                exp_w = (q_new.size() > 0) ? q_new.pop_front() : 16'hDEAD;
                check("conc_new_data", ctrl_out_data, exp_w);
                rcv_new++;
            end
            if (acc_wo) begin
                q_old.push_back(16'(16'hA000 + sent_old));
                sent_old++;
            end
            if (acc_wn) begin
                q_new.push_back(16'(16'hB000 + sent_new));
                sent_new++;
            end
        end
        check("conc_old_count", rcv_old, 40);
        check("conc_new_count", rcv_new, 40);
        ctrl_in_valid = 1'b0; avoid_in_valid = 1'b0;
        avoid_out_rdy = 1'b0; ctrl_out_rdy = 1'b0;
        tick();
        check("conc_old_drained", avoid_out_valid, 0);
        check("conc_new_drained", ctrl_out_valid, 0);

        // Mid-operation reset
        for (int i = 0; i < 5; i++) begin
            ctrl_in_valid = 1'b1;
            ctrl_in_data  = 16'(16'h50 + i);
            tick();
        end
        ctrl_in_valid = 1'b0;
        tick();
        check("mid_queued_valid", avoid_out_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", avoid_out_valid, 0);
        check("mid_rst_rdy",   ctrl_in_rdy,     0);
        check("mid_rst_data",  avoid_out_data,  0);
        rst = 1'b0;
        tick();
        check("mid_post_valid", avoid_out_valid, 0);
        check("mid_post_rdy",   ctrl_in_rdy,     1);
        ctrl_in_valid = 1'b1; ctrl_in_data = 16'h60;
        tick();
        ctrl_in_data = 16'h61;
        tick();
        ctrl_in_valid = 1'b0;
        tick();
        avoid_out_rdy = 1'b1;
        tick();
        check("mid_new_first",  avoid_out_data, 32'h60);
        tick();
        check("mid_new_second", avoid_out_data, 32'h61);
        check("mid_new_empty",  avoid_out_valid, 0);
        avoid_out_rdy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
